// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends PATTERN MSB-first, repeated count times, with start/busy/done and stall.
// Optional filler bits between repetitions are compiled in when SEQGEN_GAP_EN is defined.
module seq_generator #(
  parameter int unsigned        PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
  parameter int unsigned        CNT_W   = 8
`ifdef SEQGEN_GAP_EN
  ,
  parameter int unsigned        GAP_LEN = 2,
  parameter logic               GAP_BIT = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             stall,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
`ifdef SEQGEN_GAP_EN
  localparam int unsigned GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
`ifdef SEQGEN_GAP_EN
    ,
    S_GAP  = 2'd3
`endif
  } state_t;

  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_rem, w_rem_nx;
  logic [CNT_W-1:0] r_sent, w_sent_nx;
  logic             r_x, w_x_nx;
  logic             r_valid, w_valid_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
`ifdef SEQGEN_GAP_EN
  logic [GAP_W-1:0] r_gap, w_gap_nx;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_sent  <= '0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQGEN_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_rem   <= w_rem_nx;
      r_sent  <= w_sent_nx;
      r_x     <= w_x_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
`ifdef SEQGEN_GAP_EN
      r_gap   <= w_gap_nx;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_rem_nx   = r_rem;
    w_sent_nx  = r_sent;
`ifdef SEQGEN_GAP_EN
    w_gap_nx   = r_gap;
`endif
    w_x_nx     = 1'b0;
    w_valid_nx = 1'b0;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sent_nx = '0;
          if (count != '0) begin
            w_rem_nx   = count;
            w_idx_nx   = IDX_W'(PAT_W - 1);
            w_state_nx = S_SEND;
          end else begin
            w_state_nx = S_DONE;
          end
        end
      end
      S_SEND: begin
        if (!stall) begin
          if (r_idx == '0) begin
            w_sent_nx = r_sent + CNT_W'(1);
            w_rem_nx  = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              w_state_nx = S_DONE;
            end else begin
`ifdef SEQGEN_GAP_EN
              w_state_nx = S_GAP;
              w_gap_nx   = GAP_W'(GAP_LEN - 1);
`else
              w_idx_nx   = IDX_W'(PAT_W - 1);
`endif
            end
          end else begin
            w_idx_nx = r_idx - IDX_W'(1);
          end
        end
      end
`ifdef SEQGEN_GAP_EN
      S_GAP: begin
        if (!stall) begin
          if (r_gap == '0) begin
            w_state_nx = S_SEND;
            w_idx_nx   = IDX_W'(PAT_W - 1);
          end else begin
            w_gap_nx = r_gap - GAP_W'(1);
          end
        end
      end
`endif
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    case (w_state_nx)
      S_SEND: begin
        w_x_nx     = PATTERN[w_idx_nx];
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b1;
      end
`ifdef SEQGEN_GAP_EN
      S_GAP: begin
        w_x_nx    = GAP_BIT;
        w_busy_nx = 1'b1;
      end
`endif
      S_DONE:  w_done_nx = 1'b1;
      default: ;
    endcase
  end

  assign x        = r_x;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sent_cnt = r_sent;

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: queue-based stream model checked every cycle, plus directed literal checks.
module tb_seq_generator;

  localparam int unsigned CNT_W = 8;
  localparam logic [3:0]  PAT   = 4'b1101;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             x, valid, busy, done;
  logic [CNT_W-1:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  seq_generator dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .stall(stall),
    .x(x), .valid(valid), .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;
  } obs_t;

  obs_t             q[$];
  logic [CNT_W-1:0] m_sent = '0;

  function automatic obs_t mk(input logic xx, input logic vv, input logic bb,
                              input logic dd, input logic [CNT_W-1:0] ss);
    mk = {xx, vv, bb, dd, ss};
  endfunction

  // Whole expected output sequence of one request, one entry per displayed item
  function automatic void build(input logic [CNT_W-1:0] n);
    q.delete();
    for (int r = 0; r < int'(n); r++) begin
      for (int b = 3; b >= 0; b--) q.push_back(mk(PAT[b], 1'b1, 1'b1, 1'b0, CNT_W'(r)));
`ifdef SEQGEN_GAP_EN
      if (r != int'(n) - 1)
        for (int g = 0; g < 2; g++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, CNT_W'(r + 1)));
`endif
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, n));
  endfunction

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (!rst) begin
      q.delete();
      m_sent = '0;
    end else begin
      e = (q.size() != 0) ? q[0] : mk(1'b0, 1'b0, 1'b0, 1'b0, m_sent);
      a = {x, valid, busy, done, sent_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model t=%0t: got x=%b v=%b b=%b d=%b sent=%0d, expected x=%b v=%b b=%b d=%b sent=%0d",
                 $time, a.x, a.valid, a.busy, a.done, a.sent, e.x, e.valid, e.busy, e.done, e.sent);
      end
      if (q.size() != 0) begin
        if (!(stall && !q[0].done)) begin
          if (q[0].done) m_sent = q[0].sent;
          void'(q.pop_front());
        end
      end else if (start) begin
        build(count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    logic [3:0] sr;
    int         hits;
`ifdef SEQGEN_GAP_EN
    logic [9:0] ex3;
    logic [9:0] ev3;
`endif

    step(); step();
    chk("rst_x", 32'(x), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sent", 32'(sent_cnt), 0);
    rst = 1'b1;
    step();

    // Single pattern
    start = 1'b1; count = 8'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_x", 32'(x), 32'(PAT[3-i]));
      chk("t1_valid", 32'(valid), 1);
      step();
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_sent", 32'(sent_cnt), 1);
    step();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_pulse", 32'(done), 0);

    // Two repetitions
    start = 1'b1; count = 8'd2;
    step();
    start = 1'b0;
`ifdef SEQGEN_GAP_EN
    ex3 = 10'b1101001101;
    ev3 = 10'b1111001111;
    for (int i = 0; i < 10; i++) begin
      chk("t3_x", 32'(x), 32'(ex3[9-i]));
      chk("t3_valid", 32'(valid), 32'(ev3[9-i]));
      step();
    end
`else
    for (int i = 0; i < 8; i++) begin
      chk("t2_x", 32'(x), 32'(PAT[3-(i%4)]));
      chk("t2_valid", 32'(valid), 1);
      step();
    end
`endif
    chk("t2_done", 32'(done), 1);
    chk("t2_sent", 32'(sent_cnt), 2);
    step();

    // Stall on the second bit for three cycles
    start = 1'b1; count = 8'd1;
    step();
    start = 1'b0;
    chk("t4_msb", 32'(x), 1);
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold", 32'(x), 1);
      chk("t4_hold_valid", 32'(valid), 1);
      step();
    end
    chk("t4_hold_last", 32'(x), 1);
    stall = 1'b0;
    step();
    chk("t4_bit1", 32'(x), 0);
    step();
    chk("t4_bit0", 32'(x), 1);
    step();
    chk("t4_done", 32'(done), 1);
    step();

    // count == 0
    start = 1'b1; count = 8'd0;
    step();
    start = 1'b0;
    chk("t5a_done", 32'(done), 1);
    chk("t5a_valid", 32'(valid), 0);
    chk("t5a_sent", 32'(sent_cnt), 0);
    step();
    chk("t5a_idle", 32'(done | busy | valid), 0);

    // start while busy and while done is ignored
    start = 1'b1; count = 8'd1;
    step();
    count = 8'd5;
    step(); step();
    start = 1'b0;
    step(); step();
    chk("t5b_done", 32'(done), 1);
    chk("t5b_sent", 32'(sent_cnt), 1);
    start = 1'b1; count = 8'd7;
    step();
    start = 1'b0;
    chk("t5b_ignored", 32'(busy), 0);
    step();
    chk("t5b_still_idle", 32'(busy), 0);
    chk("t5b_sent_hold", 32'(sent_cnt), 1);

    // Asynchronous reset mid-frame
    start = 1'b1; count = 8'd3;
    step();
    start = 1'b0;
    step(); step();
    chk("t5c_pre_busy", 32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    chk("t5c_rst_outs", 32'({x, valid, busy, done}), 0);
    chk("t5c_rst_sent", 32'(sent_cnt), 0);
    step(); step();
    rst = 1'b1;
    step(); step();
    chk("t5c_idle", 32'({valid, busy}), 0);

    // Loopback into an ideal overlapping 1101 detector
    sr = 4'd0; hits = 0;
    start = 1'b1; count = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      sr = {sr[2:0], x};
      if (sr == 4'b1101) hits++;
      step();
    end
    chk("t6_detect", 32'(hits), 3);

    // Periodic stall over a multi-repetition request
    start = 1'b1; count = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      stall = (i % 3 == 1);
      step();
    end
    stall = 1'b0;
    step(); step();
    chk("t7_sent", 32'(sent_cnt), 3);

    // Maximum count
    start = 1'b1; count = 8'd255;
    step();
    start = 1'b0;
    repeat (1600) step();
    chk("t8_sent", 32'(sent_cnt), 255);
    chk("t8_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
